// File: rtl/mem_bus_pkg.sv
// Shared widths, FSM state encoding and default stall limit for the 36-bit memory bus.
package mem_bus_pkg;

  localparam int unsigned AddrW      = 18;
  localparam int unsigned DataW      = 36;
  localparam int unsigned DefTimeout = 64;
  localparam int unsigned DefTw      = 7;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StHold,
    StWr,
    StFin
  } state_e;

endpackage

// File: rtl/mem_stall_timer.sv
// Counts stalled bus cycles; expired is raised once the count reaches LIMIT-1.
module mem_stall_timer #(
  parameter int unsigned TW    = 7,
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TW'(LIMIT - 1));

endmodule

// File: rtl/mem_master_36.sv
// Memory-bus initiator: turns read, write and read-modify-write requests into bus
// transfers, honouring waitrequest and aborting with NXM when a slave never answers.
module mem_master_36
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned TW      = DefTw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AddrW-1:0] c_addr,
  input  logic             c_rd,
  input  logic             c_wr,
  input  logic [DataW-1:0] c_wrdata,
  input  logic             c_wrgo,
  output logic             c_busy,
  output logic [DataW-1:0] c_rddata,
  output logic             c_rdvalid,
  output logic             c_done,
  output logic             c_nxm,
  output logic [AddrW-1:0] m_address,
  output logic             m_read,
  output logic             m_write,
  output logic [DataW-1:0] m_writedata,
  input  logic [DataW-1:0] m_readdata,
  input  logic             m_waitrequest
);

  state_e state;
  logic   rmw;
  logic   nxm_flag;
  logic   timer_clr;
  logic   timer_en;
  logic   expired;

  always_comb begin
    timer_clr = ((state == StIdle) && (c_rd || c_wr)) || ((state == StHold) && c_wrgo);
    // Freeze at the limit so the abort edge still sees expired.
    timer_en  = ((state == StRd) || (state == StWr)) && m_waitrequest && !expired;
  end

  mem_stall_timer #(
    .TW    (TW),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      rmw         <= 1'b0;
      nxm_flag    <= 1'b0;
      c_busy      <= 1'b0;
      c_rddata    <= '0;
      c_rdvalid   <= 1'b0;
      c_done      <= 1'b0;
      c_nxm       <= 1'b0;
      m_address   <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= '0;
    end else begin
      c_rdvalid <= 1'b0;
      c_done    <= 1'b0;
      c_nxm     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (c_rd || c_wr) begin
            m_address <= c_addr;
            c_busy    <= 1'b1;
            nxm_flag  <= 1'b0;
            rmw       <= c_rd && c_wr;
            if (c_rd) begin
              m_read <= 1'b1;
              state  <= StRd;
            end else begin
              m_writedata <= c_wrdata;
              m_write     <= 1'b1;
              state       <= StWr;
            end
          end
        end
        StRd: begin
          if (!m_waitrequest) begin
            c_rddata  <= m_readdata;
            c_rdvalid <= 1'b1;
            m_read    <= 1'b0;
            state     <= rmw ? StHold : StFin;
          end else if (expired) begin
            // Aborted RMW skips the write half entirely.
            m_read   <= 1'b0;
            nxm_flag <= 1'b1;
            state    <= StFin;
          end
        end
        StHold: begin
          if (c_wrgo) begin
            m_writedata <= c_wrdata;
            m_write     <= 1'b1;
            state       <= StWr;
          end
        end
        StWr: begin
          if (!m_waitrequest) begin
            m_write <= 1'b0;
            state   <= StFin;
          end else if (expired) begin
            m_write  <= 1'b0;
            nxm_flag <= 1'b1;
            state    <= StFin;
          end
        end
        StFin: begin
          c_done <= 1'b1;
          c_nxm  <= nxm_flag;
          c_busy <= 1'b0;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master_36.sv
// Directed and randomized transactions against a bench-side slave memory and reference model.
module tb_mem_master_36;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] c_addr = '0;
  logic        c_rd = 1'b0;
  logic        c_wr = 1'b0;
  logic [35:0] c_wrdata = '0;
  logic        c_wrgo = 1'b0;
  logic        c_busy;
  logic [35:0] c_rddata;
  logic        c_rdvalid;
  logic        c_done;
  logic        c_nxm;
  logic [17:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [35:0] m_writedata;
  logic [35:0] m_readdata = '0;
  logic        m_waitrequest = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  bit [35:0] smem    [0:262143];  // what the slave actually stores
  bit [35:0] exp_mem [0:262143];  // what the requests should have left behind

  mem_master_36 #(.TIMEOUT(T), .TW(7)) dut (
    .clk           (clk),
    .reset         (reset),
    .c_addr        (c_addr),
    .c_rd          (c_rd),
    .c_wr          (c_wr),
    .c_wrdata      (c_wrdata),
    .c_wrgo        (c_wrgo),
    .c_busy        (c_busy),
    .c_rddata      (c_rddata),
    .c_rdvalid     (c_rdvalid),
    .c_done        (c_done),
    .c_nxm         (c_nxm),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] r36();
    r36 = {4'($urandom), 32'($urandom)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 read, 1 write, 2 read-modify-write. dead: slave never drops waitrequest.
  // keep: hold the request lines high until c_done is seen.
  task automatic txn(input int kind, input logic [17:0] addr, input logic [35:0] wd,
                     input int stall, input int hold, input bit dead, input bit keep);
    int rd_cyc = 0, wr_cyc = 0, ph = 0, rdv = 0, done = 0, hold_seen = 0;
    int wr_early = 0, bad = 0, rd_exp, wr_exp;
    bit go_done = 0, nxm_seen = 0, req_on = 1, exp_rdv;
    logic [35:0] rdv_data = '0;
    logic [35:0] exp_rd;
    exp_rd  = exp_mem[addr];
    exp_rdv = (kind != 1) && !dead;
    rd_exp  = (kind == 1) ? 0 : (dead ? T : stall + 1);
    wr_exp  = (kind == 0) ? 0 : (dead ? ((kind == 1) ? T : 0) : stall + 1);
    @(negedge clk);
    c_addr   = addr;
    c_rd     = (kind != 1);
    c_wr     = (kind != 0);
    c_wrdata = (kind == 1) ? wd : r36();
    for (int cyc = 0; cyc < 400 && done == 0; cyc++) begin
      @(negedge clk);
      if (!keep && req_on) begin
        c_rd = 1'b0; c_wr = 1'b0; req_on = 0; c_addr = 18'($urandom);
      end
      c_wrgo   = 1'b0;
      c_wrdata = r36();
      if (m_read && m_write) bad++;
      if ((m_read || m_write) && m_address !== addr) bad++;
      if (m_write && m_writedata !== wd) bad++;
      if (!c_busy && !c_done) bad++;
      if (c_rdvalid) begin rdv++; rdv_data = c_rddata; end
      if (c_done) begin
        done++; nxm_seen = c_nxm;
        c_rd = 1'b0; c_wr = 1'b0;
      end
      if (m_read || m_write) begin
        ph++;
        if (m_read) rd_cyc++; else wr_cyc++;
        if (m_write && kind == 2 && !go_done) wr_early++;
      end else begin
        ph = 0;
      end
      m_waitrequest = dead || (ph <= stall);
      m_readdata    = m_read ? smem[addr] : r36();
      if (m_write && !m_waitrequest) smem[addr] = m_writedata;
      if (kind == 2 && rdv > 0 && !go_done && !m_write && done == 0) begin
        if (hold_seen == hold) begin
          c_wrgo = 1'b1; c_wrdata = wd; go_done = 1;
        end else begin
          hold_seen++;
        end
      end
    end
    @(negedge clk);
    c_wrgo = 1'b0;
    m_waitrequest = 1'b1;
    if (c_done || m_read || m_write || c_busy) bad++;
    if (!dead && kind != 0) exp_mem[addr] = wd;
    check("done_count", done, 1);
    check("nxm", nxm_seen, dead);
    check("rdvalid_count", rdv, exp_rdv);
    if (exp_rdv) check("rddata", rdv_data, exp_rd);
    check("read_strobe_cycles", rd_cyc, rd_exp);
    check("write_strobe_cycles", wr_cyc, wr_exp);
    check("bus_protocol", bad, 0);
    check("write_before_wrgo", wr_early, 0);
    if (kind == 2 && !dead) check("hold_cycles", hold_seen, hold);
    check("slave_mem", smem[addr], exp_mem[addr]);
  endtask

  initial begin
    int kind;
    logic [17:0] a;
    // Reset state
    #3 reset = 1'b0;
    #1;
    check("rst_m_read", m_read, 0);
    check("rst_m_write", m_write, 0);
    check("rst_busy", c_busy, 0);
    check("rst_done", c_done, 0);
    check("rst_rdvalid", c_rdvalid, 0);
    check("rst_addr", m_address, 0);
    check("rst_wdata", m_writedata, 0);
    check("rst_rddata", c_rddata, 0);
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait read
    smem[18'o1234] = 36'o123456701234;
    exp_mem[18'o1234] = 36'o123456701234;
    txn(0, 18'o1234, '0, 0, 0, 0, 0);
    // Write with three stall cycles
    txn(1, 18'o17777, 36'o777777777777, 3, 0, 0, 0);
    // RMW with a ten-cycle pause before c_wrgo
    smem[18'o100] = 36'd5;
    exp_mem[18'o100] = 36'd5;
    txn(2, 18'o100, 36'd6, 0, 10, 0, 0);
    // Dead slave: NXM on read, then on RMW and write, then normal service
    txn(0, 18'o400000, '0, 0, 0, 1, 0);
    txn(2, 18'o400000, 36'd7, 0, 0, 1, 0);
    txn(1, 18'o400001, 36'd9, 0, 0, 1, 0);
    txn(0, 18'o1234, '0, 1, 0, 0, 0);

    // c_wrgo in IDLE must not start anything
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      c_wrgo = 1'b1; c_wrdata = r36();
      @(negedge clk);
      c_wrgo = 1'b0;
      check("idle_wrgo_strobe", {m_read, m_write, c_busy}, 3'b000);
    end

    // Request held high while busy: exactly one transfer
    txn(1, 18'o2222, 36'o1111, 2, 0, 0, 1);
    txn(2, 18'o2222, 36'o3333, 1, 2, 0, 1);

    // Reset in the middle of a stalled write
    @(negedge clk);
    c_addr = 18'o5555; c_wr = 1'b1; c_wrdata = r36();
    @(negedge clk);
    c_wr = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_m_write", m_write, 0);
    check("rst_mid_busy", c_busy, 0);
    repeat (2) @(negedge clk);
    check("rst_mid_done", c_done, 0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_quiet", {c_done, m_write, m_read}, 3'b000);
    end
    txn(0, 18'o5555, '0, 0, 0, 0, 0);

    // Randomized traffic over a small address pool so reads see earlier writes
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 2));
      a = 18'($urandom_range(0, 7)) + 18'o30000;
      txn(kind, a, r36(), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 0,
          bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
